// File: rtl/fa_serial_adder.sv
// rtl/fa_serial_adder.sv - bit-serial WIDTH-bit adder controller driving one external full-adder cell
module fa_serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic             c_reg_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [WIDTH-1:0] a_sh_d;
    logic [WIDTH-1:0] b_sh_d;
    logic [WIDTH-1:0] s_sh_d;

    // Shifts are written as shift/or so that WIDTH=1 needs no empty part-select.
    assign a_sh_d = a_sh_q >> 1;
    assign b_sh_d = b_sh_q >> 1;
    assign s_sh_d = (s_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    // FA inputs are gated by the registered RUN flag so they read 0 in IDLE/DONE.
    assign fa_a   = busy_q & a_sh_q[0];
    assign fa_b   = busy_q & b_sh_q[0];
    assign fa_cin = busy_q & c_reg_q;

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_reg_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_RUN;
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        c_reg_q <= cin;
                        s_sh_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    a_sh_q  <= a_sh_d;
                    b_sh_q  <= b_sh_d;
                    s_sh_q  <= s_sh_d;
                    c_reg_q <= fa_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= S_DONE;
                        sum_q   <= s_sh_d;
                        cout_q  <= fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa_serial_adder.sv
// tb/tb_fa_serial_adder.sv - randomized self-checking bench for fa_serial_adder with a behavioural FA
module tb_fa_serial_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_s;
    logic         fa_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int tests = 0;
    int fails = 0;

    fa_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    // Full-adder cell, described arithmetically.
    assign {fa_cout, fa_s} = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_add(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic c_v, input string tag);
        logic [W:0] expv;
        int k;
        expv = (W+1)'(a_v) + (W+1)'(b_v) + (W+1)'(c_v);
        a = a_v; b = b_v; cin = c_v; start = 1'b1;
        step();
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        k = 0;
        while (busy === 1'b1 && k < 3 * W) begin
            tests++;
            if (k < W && (fa_a !== a_v[k] || fa_b !== b_v[k])) begin
                fails++;
                $display("FAIL %s fa_bit%0d: got a=%b b=%b, want a=%b b=%b", tag, k, fa_a, fa_b, a_v[k], b_v[k]);
            end
            step();
            k++;
        end
        tests++;
        if (k !== W) begin
            fails++;
            $display("FAIL %s busy_len: got %0d cycles, want %0d", tag, k, W);
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s done_pulse: got %b, want 1", tag, done);
        end
        tests++;
        if ({cout, sum} !== expv) begin
            fails++;
            $display("FAIL %s result: got %0d, want %0d (a=%0d b=%0d cin=%0d)", tag, {cout, sum}, expv, a_v, b_v, c_v);
        end
        step();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || {fa_a, fa_b, fa_cin} !== 3'b000) begin
            fails++;
            $display("FAIL %s after_done: got done=%b busy=%b fa=%b%b%b, want 0 0 000", tag, done, busy, fa_a, fa_b, fa_cin);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        step();
        step();
        tests++;
        if (sum !== '0 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got sum=%0d cout=%b busy=%b done=%b, want 0 0 0 0", sum, cout, busy, done);
        end
        tests++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            fails++;
            $display("FAIL reset_fa: got %b%b%b, want 000", fa_a, fa_b, fa_cin);
        end
        // start asserted together with rst must be dropped
        start = 1'b1; a = 4'd7; b = 4'd7;
        step();
        rst = 1'b0; start = 1'b0;
        step();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_start_dropped: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        run_add(4'd3, 4'd5, 1'b0, "add_3_5");
        run_add(4'd15, 4'd1, 1'b0, "add_15_1");
        run_add(4'd15, 4'd15, 1'b1, "add_15_15_1");
    endtask

    task automatic test_ignore_start();
        logic [W:0] expv;
        a = 4'd9; b = 4'd6; cin = 1'b1; start = 1'b1;
        expv = 5'd16;
        step();
        start = 1'b0;
        step();
        a = 4'd0; b = 4'd0; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3 * W && done !== 1'b1; i++) step();
        tests++;
        if (done !== 1'b1 || {cout, sum} !== expv) begin
            fails++;
            $display("FAIL ignore_start: got done=%b result=%0d, want 1 %0d", done, {cout, sum}, expv);
        end
        step();
        step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL ignore_start_idle: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int last_t;
        int n_done;
        logic [W:0] expv;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        expv = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
        start = 1'b1;
        last_t = -1;
        n_done = 0;
        for (int t = 0; t < 8 * (W + 2); t++) begin
            step();
            if (done === 1'b1) begin
                n_done++;
                tests++;
                if ({cout, sum} !== expv) begin
                    fails++;
                    $display("FAIL b2b_result: got %0d, want %0d", {cout, sum}, expv);
                end
                if (last_t >= 0) begin
                    tests++;
                    if (t - last_t !== W + 2) begin
                        fails++;
                        $display("FAIL b2b_period: got %0d cycles, want %0d", t - last_t, W + 2);
                    end
                end
                last_t = t;
            end
        end
        start = 1'b0;
        tests++;
        if (n_done < 7) begin
            fails++;
            $display("FAIL b2b_count: got %0d done pulses, want at least 7", n_done);
        end
        for (int i = 0; i < W + 3; i++) step();
    endtask

    task automatic test_reset_mid_run();
        int seen;
        run_add(4'd12, 4'd7, 1'b1, "pre_reset");
        a = 4'd5; b = 4'd6; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got busy=%b done=%b sum=%0d cout=%b, want 0 0 0 0", busy, done, sum, cout);
        end
        seen = 0;
        for (int i = 0; i < 2 * W; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL mid_reset_quiet: got %0d active cycles, want 0", seen);
        end
    endtask

    task automatic test_exhaustive();
        int order[512];
        int j;
        int tmp;
        for (int i = 0; i < 512; i++) order[i] = i;
        for (int i = 511; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        for (int i = 0; i < 512; i++) begin
            run_add(W'(order[i] & 15), W'((order[i] >> 4) & 15), 1'((order[i] >> 8) & 1), "exh");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
